cp0_int_ctrl: RTL and testbench
===============================

Name: cp0_int_ctrl

Overview:
- Coprocessor-0 block on the CPU side; it receives the 6-bit device interrupt vector that the bridge builds from the timer break lines.
- Holds SR, Cause, EPC and PrID, and serves mfc0/mtc0.
- Raises the interrupt request to the pipeline, captures EPC on exception entry, and clears EXL on eret.

Parameters:
PRID, 32'h4D49_5053, read-only value returned for register 15.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
A1  input  5  CP0 register number for reads (mfc0)
A2  input  5  CP0 register number for writes (mtc0)
DIn  input  32  mtc0 write data
WE  input  1  mtc0 write enable
PC  input  32  address of the victim instruction, sampled on EXLSet
BDIn  input  1  victim instruction is in a delay slot
ExcCodeIn  input  5  exception code; 0 means interrupt
HWInt  input  6  device interrupt lines, bit i corresponds to IP[i+2] / Cause bit i+10
EXLSet  input  1  pipeline takes an exception or interrupt this cycle
EXLClr  input  1  eret commits this cycle
IntReq  output  1  interrupt request to the pipeline
EPC  output  32  current EPC register, drives the eret target
DOut  output  32  read data for A1

Behaviour:
Register map:
- 12 = SR: IM = bits[15:10], EXL = bit 1, IE = bit 0; all other bits read 0.
- 13 = Cause: BD = bit 31, IP = bits[15:10], ExcCode = bits[6:2]; other bits read 0.
- 14 = EPC.
- 15 = PrID.
- Any other A1 reads 32'h0.

Reset (synchronous, reset=1 at the edge):
- SR, Cause, EPC cleared to 0.
- Outputs after that edge: IntReq=0, EPC=0, DOut=0 for A1=12/13/14, PRID for A1=15.

Cause.IP:
- Sampled from HWInt on every rising edge that is not a reset edge.
- The read value therefore lags HWInt by 1 cycle.
- Software writes do not affect it.

IntReq:
- Combinational: IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- Uses live HWInt, with no added latency.

Exception entry (EXLSet=1):
- Sets EXL=1.
- Loads EPC = {PC[31:2], 2'b00}.
- Loads Cause.BD = BDIn and Cause.ExcCode = ExcCodeIn.
- EXL=1 masks IntReq starting from the next cycle.

eret (EXLClr=1):
- Clears EXL=0.
- EPC is unchanged.

mtc0 (WE=1):
- A2=12: loads IM, EXL and IE from DIn[15:10], DIn[1] and DIn[0].
- A2=14: loads EPC = {DIn[31:2], 2'b00}.
- A2=13, A2=15 or an unmapped number: write ignored.

Priority when events coincide in the same cycle:
- EXLSet > EXLClr > WE for EXL and EPC.
- If EXLSet=1 and WE targets SR: IM and IE take DIn, and EXL is forced to 1.
- If EXLClr=1 and WE targets SR: IM and IE take DIn, and EXL is forced to 0.
- If EXLSet=1 and WE targets EPC: EPC takes PC.

Reads:
- DOut is combinational from the registered state selected by A1.
- No write bypass: a read of the register being written in the same cycle returns the old value; the new value is visible the next cycle.

Widths:
- All registers are 32-bit.
- Unused bits are held at 0 and never stored.

Reset mid-operation:
- reset=1 overrides EXLSet, EXLClr and WE in the same cycle.
- All state returns to reset values.

Test Plan:
- Reset, then read A1=12,13,14,15 -> 0, 0, 0, 32'h4D49_5053; IntReq=0 even with HWInt=6'b111111.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 -> IntReq=1 in the same cycle; Cause reads 32'h0000_0400 one cycle later; HWInt=6'b000010 -> IntReq=0.
- With IntReq high, pulse EXLSet with PC=32'h0000_3047, BDIn=1, ExcCodeIn=0 -> EPC=32'h0000_3044, SR reads 32'h0000_0403, Cause[31]=1, IntReq=0 next cycle; then pulse EXLClr -> SR reads 32'h0000_0401 and IntReq=1 again.
- Same-cycle EXLSet + WE(A2=14, DIn=32'h1234) with PC=32'h3000 -> EPC=32'h3000. Same-cycle EXLClr + WE(A2=12, DIn=32'h0000_FC03) -> SR reads 32'h0000_FC01.
- mtc0 A2=13 with DIn=32'hFFFF_FFFF and A2=15 with DIn=0 -> Cause and PrID unchanged. mtc0 A2=14 with DIn=32'h0000_300B -> EPC=32'h0000_3008; reading A1=14 in the write cycle returns the old value.
- Assert reset in the same cycle as EXLSet=1 and WE=1 -> all registers 0 on the next cycle.

Source files
------------

// File: rtl/cp0_int_ctrl_if.sv
// Bus between the pipeline and CP0.
// The master (pipeline side) drives the mfc0/mtc0 controls, the exception and eret
// strobes, and the device interrupt lines.
// The slave (CP0) returns IntReq, EPC and the mfc0 read data DOut.
interface cp0_int_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLSet, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, PC, BDIn, ExcCodeIn, HWInt, EXLSet, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt/exception control: SR, Cause, EPC and PrID.
// Ports:
//   clk   - system clock; all state updates on the rising edge
//   reset - synchronous, active-high reset
//   bus   - cp0_int_ctrl_if.slave, carrying:
//             mfc0 read port (A1 -> DOut)
//             mtc0 write port (A2, DIn, WE)
//             exception entry (EXLSet, PC, BDIn, ExcCodeIn)
//             eret (EXLClr)
//             device interrupts (HWInt)
//             IntReq and EPC outputs
module cp0_int_ctrl #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic           clk,
    input  logic           reset,
    cp0_int_ctrl_if.slave  bus
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int unsigned IM_W  = 6;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned EPC_W = 30;

    // Only the implemented fields are stored; every other bit reads as zero.
    logic [IM_W-1:0]  im_q,      im_d;
    logic             exl_q,     exl_d;
    logic             ie_q,      ie_d;
    logic             bd_q,      bd_d;
    logic [IM_W-1:0]  ip_q,      ip_d;
    logic [EXC_W-1:0] exccode_q, exccode_d;
    logic [EPC_W-1:0] epc_q,     epc_d;

    logic sr_we_c;
    logic epc_we_c;

    // Bits of the bus that no register field stores.
    logic unused_bits_c;
    assign unused_bits_c = ^{bus.PC[1:0], bus.DIn[9:2]};

    assign sr_we_c  = bus.WE && (bus.A2 == REG_SR);
    assign epc_we_c = bus.WE && (bus.A2 == REG_EPC);

    // Next state. For EXL and EPC, EXLSet beats EXLClr, which beats mtc0.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = bus.HWInt;

        if (sr_we_c) begin
            im_d  = bus.DIn[15:10];
            ie_d  = bus.DIn[0];
            exl_d = bus.DIn[1];
        end
        if (epc_we_c) begin
            epc_d = bus.DIn[31:2];
        end

        if (bus.EXLSet) begin
            exl_d     = 1'b1;
            epc_d     = bus.PC[31:2];
            bd_d      = bus.BDIn;
            exccode_d = bus.ExcCodeIn;
        end else if (bus.EXLClr) begin
            exl_d = 1'b0;
        end
    end

    // State register; reset takes precedence over every update source.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // IntReq uses live HWInt so a pending device line is seen without latency.
    assign bus.IntReq = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    assign bus.EPC    = {epc_q, 2'b00};

    // mfc0 read mux from registered state; no bypass of same-cycle writes.
    always_comb begin
        bus.DOut = 32'h0;
        unique case (bus.A1)
            REG_SR:    bus.DOut = {16'h0, im_q, 8'h0, exl_q, ie_q};
            REG_CAUSE: bus.DOut = {bd_q, 15'h0, ip_q, 3'h0, exccode_q, 2'b00};
            REG_EPC:   bus.DOut = {epc_q, 2'b00};
            REG_PRID:  bus.DOut = PRID;
            default:   bus.DOut = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed, table-driven bench for cp0_int_ctrl.
// Each vector gives the inputs for one cycle and the outputs expected before that
// cycle's rising edge; state effects show up in the following vectors.
module tb_cp0_int_ctrl;
    logic clk = 1'b0;
    logic reset;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        set;
        logic        clr;
        logic        exp_irq;
        logic [31:0] exp_epc;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] PRID_V = 32'h4D49_5053;

    function automatic vec_t mk(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] din, input logic we, input logic [31:0] pc,
                                input logic bd, input logic [4:0] exc, input logic [5:0] hw,
                                input logic set, input logic clr, input logic irq,
                                input logic [31:0] epc, input logic [31:0] dout);
        vec_t v;
        v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc;
        v.bd = bd; v.exc = exc; v.hw = hw; v.set = set; v.clr = clr;
        v.exp_irq = irq; v.exp_epc = epc; v.exp_dout = dout;
        return v;
    endfunction

    task automatic check32(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.A1        = v.a1;
        bus.A2        = v.a2;
        bus.DIn       = v.din;
        bus.WE        = v.we;
        bus.PC        = v.pc;
        bus.BDIn      = v.bd;
        bus.ExcCodeIn = v.exc;
        bus.HWInt     = v.hw;
        bus.EXLSet    = v.set;
        bus.EXLClr    = v.clr;
    endtask

    initial begin
        logic [5:0] pats [4];
        logic [5:0] prev;

        //          rst a1  a2  din            we pc            bd exc hw     set clr irq epc           dout
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h3F, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 14, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 15, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        PRID_V));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 12, 12, 32'h0401,    1, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 0, 1, 32'h0,        32'h0401));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 0, 1, 32'h0,        32'h0400));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h02, 0, 0, 0, 32'h0,        32'h0400));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h3047,     1, 0, 6'h01, 1, 0, 1, 32'h0,        32'h0401));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 0, 0, 32'h3044,     32'h0403));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 0, 0, 32'h3044,     32'h8000_0400));
        vecs.push_back(mk(0, 14, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 1, 0, 32'h3044,     32'h3044));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h01, 0, 0, 1, 32'h3044,     32'h0401));
        vecs.push_back(mk(0, 14, 14, 32'h1234,    1, 32'h3000,     0, 4, 6'h00, 1, 0, 0, 32'h3044,     32'h3044));
        vecs.push_back(mk(0, 14, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3000,     32'h3000));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3000,     32'h0010));
        vecs.push_back(mk(0, 12, 12, 32'hFC03,    1, 32'h0,        0, 0, 6'h00, 0, 1, 0, 32'h3000,     32'h0403));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h20, 0, 0, 1, 32'h3000,     32'hFC01));
        vecs.push_back(mk(0, 13, 13, 32'hFFFF_FFFF,1, 32'h0,       0, 0, 6'h00, 0, 0, 0, 32'h3000,     32'h8010));
        vecs.push_back(mk(0, 13, 15, 32'h0,       1, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3000,     32'h0010));
        vecs.push_back(mk(0, 15, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3000,     PRID_V));
        vecs.push_back(mk(0, 14, 14, 32'h300B,    1, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3000,     32'h3000));
        vecs.push_back(mk(0, 14, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3008,     32'h3008));
        vecs.push_back(mk(0, 5,  0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h3008,     32'h0));
        vecs.push_back(mk(0, 12, 12, 32'hFFFF_FFFF,1, 32'h0,       0, 0, 6'h00, 0, 0, 0, 32'h3008,     32'hFC01));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h3F, 0, 0, 0, 32'h3008,     32'hFC03));
        vecs.push_back(mk(1, 14, 14, 32'h5555,    1, 32'h4000,     1, 3, 6'h00, 1, 0, 0, 32'h3008,     32'h3008));
        vecs.push_back(mk(0, 13, 0, 32'h0,        0, 32'h0,        0, 0, 6'h3F, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 12, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 14, 0, 32'h0,        0, 32'h0,        0, 0, 6'h00, 0, 0, 0, 32'h0,        32'h0));

        // Reset with all strobes idle and no device lines asserted.
        drive(mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 6'h00, 0, 0, 0, 32'h0, 32'h0));
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check32("irq",  i, 32'(bus.IntReq), 32'(vecs[i].exp_irq));
            check32("epc",  i, bus.EPC,  vecs[i].exp_epc);
            check32("dout", i, bus.DOut, vecs[i].exp_dout);
            @(negedge clk);
        end

        // Cause.IP follows HWInt one cycle behind across changing patterns.
        pats[0] = 6'h2A; pats[1] = 6'h15; pats[2] = 6'h3F; pats[3] = 6'h00;
        prev = 6'h00;
        for (int i = 0; i < 4; i++) begin
            drive(mk(0, 13, 0, 32'h0, 0, 32'h0, 0, 0, pats[i], 0, 0, 0, 32'h0, 32'h0));
            #2;
            check32("ip_lag", i, bus.DOut, {16'h0, prev, 10'h0});
            prev = pats[i];
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
